// File: rtl/bnn_inference_sequencer.sv
// Sequences the shared XNOR-popcount datapath through one BNN inference:
// image buffering, hidden-layer thresholding and output argmax.
module bnn_inference_sequencer #(
  parameter  int N_IN  = 64,
  parameter  int N_HID = 16,
  parameter  int N_OUT = 10,
  localparam int W_IN  = N_IN / 8,
  localparam int W_HID = N_HID / 8,
  localparam int WW    = (W_IN > 1) ? $clog2(W_IN) : 1,
  localparam int SW    = $clog2(N_HID + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          pix_valid,
  input  logic [7:0]    pix_data,
  output logic          pix_ready,
  output logic          dp_req,
  output logic          dp_layer,
  output logic [3:0]    dp_neuron,
  output logic [WW-1:0] dp_word,
  output logic [7:0]    dp_act,
  input  logic [3:0]    dp_pop,
  output logic          busy,
  output logic          done,
  output logic [3:0]    class_out,
  output logic [SW-1:0] score_out
);

  // state   | meaning
  // ST_IDLE | waiting for the first pixel beat
  // ST_LOAD | buffering image words 1..W_IN-1
  // ST_L1   | hidden layer: W_IN issues + 1 finalize per neuron
  // ST_L2   | output layer: W_HID issues + 1 finalize per class, argmax
  // ST_DONE | one-cycle result pulse
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_L1, ST_L2, ST_DONE} state_t;

  localparam int AW    = $clog2(N_IN + 1);
  localparam int W_MAX = (W_IN > W_HID) ? W_IN : W_HID;
  localparam int CW    = $clog2(W_MAX + 1);
  localparam int HW    = (W_HID > 1) ? $clog2(W_HID) : 1;

  localparam logic [CW-1:0] LAST_LOAD = CW'(W_IN - 1);
  localparam logic [CW-1:0] W_IN_C    = CW'(W_IN);
  localparam logic [CW-1:0] W_HID_C   = CW'(W_HID);
  localparam logic [3:0]    LAST_HID  = 4'(N_HID - 1);
  localparam logic [3:0]    LAST_OUT  = 4'(N_OUT - 1);
  localparam logic [AW-1:0] THRESH    = AW'(N_IN / 2);

  state_t                  state_q, state_d;
  logic [CW-1:0]           word_q;
  logic [3:0]              neuron_q;
  logic [AW-1:0]           acc_q;
  logic [7:0]              img_q [W_IN];
  logic [W_HID-1:0][7:0]   hid_q;
  logic [SW-1:0]           best_q;
  logic [3:0]              best_idx_q;

  logic                    accept;
  logic                    issue;
  logic                    fin;
  logic                    last_neuron;
  logic                    take_best;
  logic [AW-1:0]           acc_sum;
  logic [SW-1:0]           score;

  always_comb begin
    state_d     = state_q;
    issue       = 1'b0;
    fin         = 1'b0;
    last_neuron = 1'b0;
    dp_act      = '0;
    pix_ready   = ena && (state_q == ST_IDLE || state_q == ST_LOAD);
    accept      = pix_valid && pix_ready;
    acc_sum     = acc_q + AW'(dp_pop);
    score       = acc_sum[SW-1:0];
    take_best   = (neuron_q == 4'd0) || (score > best_q);
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_LOAD;
      ST_LOAD: if (accept && word_q == LAST_LOAD) state_d = ST_L1;
      ST_L1: begin
        if (word_q == W_IN_C) begin
          fin         = 1'b1;
          last_neuron = (neuron_q == LAST_HID);
          if (last_neuron) state_d = ST_L2;
        end else begin
          issue  = 1'b1;
          dp_act = img_q[word_q[WW-1:0]];
        end
      end
      ST_L2: begin
        if (word_q == W_HID_C) begin
          fin         = 1'b1;
          last_neuron = (neuron_q == LAST_OUT);
          if (last_neuron) state_d = ST_DONE;
        end else begin
          issue  = 1'b1;
          dp_act = hid_q[word_q[HW-1:0]];
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign dp_req    = ena && issue;
  assign dp_layer  = (state_q == ST_L2);
  assign dp_neuron = neuron_q;
  assign dp_word   = word_q[WW-1:0];
  assign busy      = (state_q == ST_L1) || (state_q == ST_L2);
  assign done      = (state_q == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state_q <= ST_IDLE;
    else if (ena) state_q <= state_d;
  end

  // Popcounts arrive one cycle after their issue, so word 0 adds nothing and
  // the finalize cycle adds the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q     <= '0;
      neuron_q   <= '0;
      acc_q      <= '0;
      hid_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      class_out  <= '0;
      score_out  <= '0;
      for (int i = 0; i < W_IN; i++) img_q[i] <= '0;
    end else if (ena) begin
      case (state_q)
        ST_IDLE, ST_LOAD: begin
          if (accept) begin
            img_q[word_q[WW-1:0]] <= pix_data;
            word_q   <= (word_q == LAST_LOAD) ? '0 : word_q + CW'(1);
            acc_q    <= '0;
            neuron_q <= '0;
          end
        end
        ST_L1, ST_L2: begin
          if (fin) begin
            word_q   <= '0;
            acc_q    <= '0;
            neuron_q <= last_neuron ? 4'd0 : neuron_q + 4'd1;
            if (state_q == ST_L1) begin
              hid_q[neuron_q[HW+2:3]][neuron_q[2:0]] <= (acc_sum >= THRESH);
            end else begin
              if (take_best) begin
                best_q     <= score;
                best_idx_q <= neuron_q;
              end
              if (last_neuron) begin
                class_out <= take_best ? neuron_q : best_idx_q;
                score_out <= take_best ? score : best_q;
              end
            end
          end else begin
            word_q <= word_q + CW'(1);
            if (word_q != '0) acc_q <= acc_sum;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
